seq_mul: RTL and testbench

Iterative, handshaked N×N→2N multiplier that retires R multiplier bits per clock, trading latency for area against the single-cycle combinational array multiplier. Sits between an issue stage and a writeback stage. Operands are accepted on a valid/ready pair and the product is returned on a valid/ready pair. One operation is in flight at a time.

---
 rtl/seq_mul_pkg.sv | 31 +++
 rtl/seq_mul_step.sv | 26 ++
 rtl/seq_mul.sv | 150 +++++++++++++++
 tb/tb_seq_mul.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the iterative multiplier seq_mul.
// Holds the FSM state encoding and the step-count and counter-width helpers
// that size the step counter for a given operand width and radix.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default configuration: 16-bit operands, one multiplier bit per cycle.
  localparam int DEF_N = 16;
  localparam int DEF_R = 1;
  localparam int STEPS = DEF_N / DEF_R;

  // Number of RUN cycles needed to consume all multiplier bits.
  function automatic int step_count(input int n, input int r);
    return n / r;
  endfunction

  // Width of the step counter; never narrower than one bit so that a
  // single-step configuration (R == N) still has a legal vector.
  function automatic int cnt_width(input int n, input int r);
    int s;
    s = n / r;
    if (s <= 1) return 1;
    return $clog2(s);
  endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One radix-2^R partial-product step of the shift-and-add multiplier.
// Adds (bits x mcand) to the accumulator as R shifted conditional adds,
// with bit i of the multiplier slice contributing mcand << i.
module seq_mul_step
  import seq_mul_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int R = DEF_R
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] mcand,
  input  logic [R-1:0]   bits,
  output logic [2*N-1:0] acc_next
);

  // Chain of conditional adds, one per multiplier bit in this slice.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < R; i++) begin
      if (bits[i]) begin
        acc_next = acc_next + (mcand << i);
      end
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Iterative N x N -> 2N handshaked multiplier retiring R multiplier bits
// per clock. One operation in flight; product held in DONE until taken.
// Optional feature macro: SEQ_MUL_SIGNED_EN adds the is_signed port and
// two's-complement support (magnitudes multiplied, result negated at the
// RUN->DONE transition when the operand signs differ).
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int R = DEF_R
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic           is_signed,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] o,
  output logic           busy
);

  localparam int NSTEPS = step_count(N, R);
  localparam int CW     = cnt_width(N, R);
  localparam int W2     = 2 * N;

  // Reject configurations where R does not evenly split the operand.
  if ((N < 2) || (R < 1) || (R > N) || ((N % R) != 0)) begin : g_bad_cfg
    $error("seq_mul: N must be >= 2 and R must divide N");
  end

  state_t state;
  state_t state_next;

  logic [W2-1:0] mcand;
  logic [W2-1:0] acc;
  logic [W2-1:0] acc_step;
  logic [W2-1:0] acc_final;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          last_step;

  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;

`ifdef SEQ_MUL_SIGNED_EN
  logic          neg;
  logic          a_neg;
  logic          b_neg;

  // In signed mode the array only ever sees magnitudes; the sign of the
  // product is remembered separately and applied once at the end.
  always_comb begin
    a_neg = is_signed & a[N-1];
    b_neg = is_signed & b[N-1];
    op_a  = a_neg ? -a : a;
    op_b  = b_neg ? -b : b;
  end

  // Negate the completed sum when exactly one operand was negative.
  always_comb begin
    acc_final = neg ? -acc_step : acc_step;
  end
`else
  // Unsigned only: operands go straight into the datapath.
  always_comb begin
    op_a      = a;
    op_b      = b;
    acc_final = acc_step;
  end
`endif

  assign last_step = (cnt == CW'(NSTEPS - 1));

  seq_mul_step #(
    .N (N),
    .R (R)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .bits     (mplier[R-1:0]),
    .acc_next (acc_step)
  );

  // State register; reset always lands in IDLE, dropping any in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode for the accept / iterate / deliver sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on acceptance, then shift-and-add each RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{N{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg    <= a_neg ^ b_neg;
`endif
          end
        end
        RUN: begin
          acc    <= last_step ? acc_final : acc_step;
          mcand  <= mcand << R;
          mplier <= mplier >> R;
          cnt    <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs come from registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign o         = acc;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: two instances (R=1 and R=4) driven with
// directed vectors whose products were worked out by hand, plus a short
// back-to-back run checked against a queue of expected products.
module tb_seq_mul;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        isSigned;
  logic        inValid  [2];
  logic        outReady [2];
  logic        inReady  [2];
  logic        outValid [2];
  logic        busy     [2];
  logic [31:0] prod     [2];

  int checks;
  int errors;
  int stepsOf [2];

  seq_mul #(.N(N), .R(1)) u_mul1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid[0]),
    .in_ready  (inReady[0]),
    .a         (a),
    .b         (b),
`ifdef SEQ_MUL_SIGNED_EN
    .is_signed (isSigned),
`endif
    .out_valid (outValid[0]),
    .out_ready (outReady[0]),
    .o         (prod[0]),
    .busy      (busy[0])
  );

  seq_mul #(.N(N), .R(4)) u_mul4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid[1]),
    .in_ready  (inReady[1]),
    .a         (a),
    .b         (b),
`ifdef SEQ_MUL_SIGNED_EN
    .is_signed (isSigned),
`endif
    .out_valid (outValid[1]),
    .out_ready (outReady[1]),
    .o         (prod[1]),
    .busy      (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for the unit to be ready, then present one operand pair for one edge.
  task automatic applyStimulus(input int u, input logic [15:0] va, input logic [15:0] vb, input logic sgn);
    int k;
    k = 0;
    @(negedge clk);
    while (!inReady[u] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) checkOutput("ready_timeout", 0, 1);
    a = va;
    b = vb;
    isSigned = sgn;
    inValid[u] = 1'b1;
    @(posedge clk);
    #1;
    inValid[u] = 1'b0;
  endtask

  // Count cycles from acceptance until out_valid, checking in_ready/busy on the way.
  task automatic waitResult(input int u, output logic [31:0] res, output int lat);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if (outValid[u]) break;
      checkOutput("run_in_ready", inReady[u], 0);
      checkOutput("run_busy", busy[u], 1);
    end
    if (!outValid[u]) checkOutput("valid_timeout", 0, 1);
    checkOutput("done_in_ready", inReady[u], 0);
    res = prod[u];
  endtask

  // Accept the product and confirm the unit is back in IDLE the next cycle.
  task automatic takeOutput(input int u);
    @(negedge clk);
    outReady[u] = 1'b1;
    @(posedge clk);
    #1;
    outReady[u] = 1'b0;
    checkOutput("post_xfer_in_ready", inReady[u], 1);
    checkOutput("post_xfer_valid", outValid[u], 0);
  endtask

  task automatic runOp(input int u, input logic [15:0] va, input logic [15:0] vb, input logic sgn,
                       input logic [31:0] exp, input string tag);
    logic [31:0] res;
    int lat;
    applyStimulus(u, va, vb, sgn);
    waitResult(u, res, lat);
    checkOutput(tag, res, exp);
    checkOutput({tag, "_lat"}, lat, stepsOf[u]);
    takeOutput(u);
  endtask

  logic [15:0] vecA [6];
  logic [15:0] vecB [6];
  logic [31:0] expQ [$];

  initial begin
    logic [31:0] res;
    int lat;
    int issued;
    int got;
    int lastOut;
    logic [31:0] expVal;

    checks = 0;
    errors = 0;
    stepsOf[0] = 16;
    stepsOf[1] = 4;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    isSigned = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inValid[i] = 1'b0;
      outReady[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_in_ready", inReady[i], 1);
      checkOutput("rst_out_valid", outValid[i], 0);
      checkOutput("rst_busy", busy[i], 0);
      checkOutput("rst_o", prod[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Largest unsigned operands, one bit per cycle.
    runOp(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "r1_max");

    // Radix-16 unit: zero multiplier, then a single high multiplier bit.
    runOp(1, 16'h1234, 16'h0000, 1'b0, 32'h00000000, "r4_zero");
    runOp(1, 16'h0001, 16'h8000, 1'b0, 32'h00008000, "r4_msb");
    runOp(1, 16'hABCD, 16'h1234, 1'b0, 32'h0C374FA4, "r4_mixed");

    // Backpressure: product must hold while out_ready stays low.
    applyStimulus(1, 16'h0003, 16'h0005, 1'b0);
    waitResult(1, res, lat);
    checkOutput("bp_o", res, 32'd15);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a = 16'hFFFF;
      b = 16'hFFFF;
      inValid[1] = (k % 3 == 0);
      #1;
      checkOutput("bp_hold_o", prod[1], 32'd15);
      checkOutput("bp_hold_valid", outValid[1], 1);
      checkOutput("bp_hold_ready", inReady[1], 0);
    end
    @(negedge clk);
    inValid[1] = 1'b0;
    takeOutput(1);
    checkOutput("bp_retain_o", prod[1], 32'd15);

`ifdef SEQ_MUL_SIGNED_EN
    runOp(0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1m1");
    runOp(0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_minmin");
    runOp(0, 16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA, "s_3xm2");
    runOp(0, 16'h0003, 16'hFFFE, 1'b0, 32'h0002FFFA, "u_3x65534");
    runOp(1, 16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA, "s4_3xm2");
`endif

    // Reset during RUN: the in-flight product is dropped.
    applyStimulus(0, 16'hFFFF, 16'h0003, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_in_ready", inReady[0], 1);
    checkOutput("midrst_valid", outValid[0], 0);
    checkOutput("midrst_o", prod[0], 0);
    checkOutput("midrst_busy", busy[0], 0);
    runOp(0, 16'd5, 16'd7, 1'b0, 32'd35, "post_rst");

    // Back-to-back operations with out_ready held high on the R=4 unit.
    vecA[0] = 16'h0002; vecB[0] = 16'h0003;
    vecA[1] = 16'hFFFF; vecB[1] = 16'h0001;
    vecA[2] = 16'h00FF; vecB[2] = 16'h0100;
    vecA[3] = 16'h1234; vecB[3] = 16'h5678;
    vecA[4] = 16'h8001; vecB[4] = 16'h0002;
    vecA[5] = 16'hFFFF; vecB[5] = 16'hFFFF;
    @(negedge clk);
    isSigned = 1'b0;
    a = vecA[0];
    b = vecB[0];
    inValid[1] = 1'b1;
    outReady[1] = 1'b1;
    issued = 0;
    got = 0;
    lastOut = -1;
    for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (outValid[1]) begin
        if (expQ.size() == 0) begin
          checkOutput("b2b_dup", 1, 0);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("b2b_o", prod[1], expVal);
        end
        if (lastOut >= 0) checkOutput("b2b_ii", cyc - lastOut, stepsOf[1] + 2);
        lastOut = cyc;
        got++;
      end
      if (inReady[1] && inValid[1]) begin
        expQ.push_back({16'h0, a} * {16'h0, b});
        issued++;
        @(posedge clk);
        #1;
        if (issued == 6) begin
          inValid[1] = 1'b0;
        end else begin
          a = vecA[issued];
          b = vecB[issued];
        end
      end
    end
    checkOutput("b2b_count", got, 6);
    checkOutput("b2b_left", expQ.size(), 0);
    @(negedge clk);
    outReady[1] = 1'b0;
    inValid[1] = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
